// File: rtl/shared_dp_scheduler.sv
// Round-robin scheduler that time-shares one external combinational datapath
// among NREQ requesters, one transaction in flight at a time.
module shared_dp_scheduler #(
  parameter int NREQ   = 4,
  parameter int IN_W   = 41,
  parameter int OUT_W  = 21,
  parameter int SETTLE = 2,
  localparam int ID_W  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 clock,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*IN_W-1:0] req_data,
  output logic [IN_W-1:0]      dp_in,
  input  logic [OUT_W-1:0]     dp_out,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ID_W-1:0]      rsp_id,
  output logic [OUT_W-1:0]     rsp_data,
  output logic                 busy
);

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_RESP
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [IN_W-1:0]    dp_in_q, dp_in_d;
  logic [ID_W-1:0]    rsp_id_q, rsp_id_d;
  logic [OUT_W-1:0]   rsp_data_q, rsp_data_d;
  logic               rsp_valid_q, rsp_valid_d;

  logic               found_c;
  logic [ID_W-1:0]    grant_idx_c;
  logic [ID_W-1:0]    cand_c;

  // Search starts one past the last winner so every requester gets a turn.
  always_comb begin
    found_c     = 1'b0;
    grant_idx_c = '0;
    cand_c      = '0;
    for (int i = 1; i <= NREQ; i++) begin
      cand_c = ID_W'((int'(ptr_q) + i) % NREQ);
      if (!found_c && req_valid[cand_c]) begin
        found_c     = 1'b1;
        grant_idx_c = cand_c;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (rst_n && (state_q == S_IDLE) && found_c) begin
      req_ready[grant_idx_c] = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ptr_d       = ptr_q;
    dp_in_d     = dp_in_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    rsp_valid_d = rsp_valid_q;
    case (state_q)
      S_IDLE: begin
        if (found_c) begin
          dp_in_d  = req_data[int'(grant_idx_c)*IN_W +: IN_W];
          rsp_id_d = grant_idx_c;
          ptr_d    = grant_idx_c;
          cnt_d    = CNT_W'(SETTLE);
          state_d  = S_SETTLE;
        end
      end
      S_SETTLE: begin
        cnt_d = cnt_q - CNT_W'(1);
        // The datapath has had SETTLE cycles to propagate dp_in by now.
        if (cnt_q == CNT_W'(1)) begin
          rsp_data_d  = dp_out;
          rsp_valid_d = 1'b1;
          state_d     = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      ptr_q       <= ID_W'(NREQ - 1);
      dp_in_q     <= '0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ptr_q       <= ptr_d;
      dp_in_q     <= dp_in_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign dp_in     = dp_in_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_valid = rsp_valid_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_shared_dp_scheduler.sv
// Directed bench for shared_dp_scheduler: default instance plus a SETTLE=1 instance.
module tb_shared_dp_scheduler;

  logic         clock = 1'b0;
  logic         rst_n = 1'b0;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [163:0] req_data;
  logic [40:0]  dp_in;
  logic [20:0]  dp_out;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [1:0]   rsp_id;
  logic [20:0]  rsp_data;
  logic         busy;

  logic [3:0]   bReqValid;
  logic [3:0]   bReqReady;
  logic [163:0] bReqData;
  logic [40:0]  bDpIn;
  logic [20:0]  bDpOut;
  logic         bRspValid;
  logic         bRspReady;
  logic [1:0]   bRspId;
  logic [20:0]  bRspData;
  logic         bBusy;

  int vectors = 0;
  int miscompares = 0;

  logic [40:0] rrData [4] = '{41'h100_0000_0011, 41'h0F0_F0F0_F0F1, 41'h123_4567_89AB, 41'h1AB_CDEF_0123};

  always #5 clock = ~clock;

  shared_dp_scheduler dut (
    .clock(clock), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
    .dp_in(dp_in), .dp_out(dp_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .busy(busy)
  );

  shared_dp_scheduler #(.SETTLE(1)) dutS1 (
    .clock(clock), .rst_n(rst_n),
    .req_valid(bReqValid), .req_ready(bReqReady), .req_data(bReqData),
    .dp_in(bDpIn), .dp_out(bDpOut),
    .rsp_valid(bRspValid), .rsp_ready(bRspReady), .rsp_id(bRspId), .rsp_data(bRspData),
    .busy(bBusy)
  );

  // Call at a negedge; returns the one-hot grant seen in that or a later cycle, 0 on timeout.
  task automatic wait_grant(output logic [3:0] g);
    g = '0;
    for (int n = 0; n < 40; n++) begin
      #1;
      if (req_ready != 4'b0) begin
        g = req_ready;
        return;
      end
      @(negedge clock);
    end
  endtask

  // Number of cycles until rsp_valid is seen, 0 on timeout.
  task automatic wait_rsp(output int n);
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clock);
      #1;
      if (rsp_valid) begin
        n = i;
        return;
      end
    end
  endtask

  task automatic test_reset();
    req_valid = 4'b1111; req_data = '0; dp_out = '0; rsp_ready = 1'b0;
    bReqValid = '0; bReqData = '0; bDpOut = '0; bRspReady = 1'b0;
    rst_n = 1'b0;
    @(negedge clock); #1;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy got=%0h exp=0", busy); end
    vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_rsp_valid got=%0h exp=0", rsp_valid); end
    vectors++; if (dp_in !== 41'h0) begin miscompares++; $display("[TB] FAIL reset_dp_in got=%0h exp=0", dp_in); end
    vectors++; if (rsp_data !== 21'h0) begin miscompares++; $display("[TB] FAIL reset_rsp_data got=%0h exp=0", rsp_data); end
    vectors++; if (rsp_id !== 2'd0) begin miscompares++; $display("[TB] FAIL reset_rsp_id got=%0h exp=0", rsp_id); end
    vectors++; if (req_ready !== 4'b0000) begin miscompares++; $display("[TB] FAIL reset_req_ready got=%b exp=0000", req_ready); end
    req_valid = 4'b0000;
    @(negedge clock);
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    logic [3:0] g;
    int n;
    req_data[40:0] = 41'h0DE_ADBE_EF42;
    req_valid = 4'b0001; rsp_ready = 1'b1; dp_out = 21'h1C0DE;
    wait_grant(g);
    vectors++; if (g !== 4'b0001) begin miscompares++; $display("[TB] FAIL single_grant got=%b exp=0001", g); end
    @(negedge clock); #1;
    vectors++; if (dp_in !== 41'h0DE_ADBE_EF42) begin miscompares++; $display("[TB] FAIL single_dp_in got=%0h exp=0deadbeef42", dp_in); end
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("[TB] FAIL single_busy got=%0h exp=1", busy); end
    vectors++; if (req_ready !== 4'b0000) begin miscompares++; $display("[TB] FAIL single_ready_in_settle got=%b exp=0000", req_ready); end
    req_valid = 4'b0000;
    wait_rsp(n);
    vectors++; if (n + 1 !== 3) begin miscompares++; $display("[TB] FAIL single_latency got=%0d exp=3", n + 1); end
    vectors++; if (rsp_id !== 2'd0) begin miscompares++; $display("[TB] FAIL single_rsp_id got=%0d exp=0", rsp_id); end
    vectors++; if (rsp_data !== 21'h1C0DE) begin miscompares++; $display("[TB] FAIL single_rsp_data got=%0h exp=1c0de", rsp_data); end
    dp_out = 21'h00BAD;
    @(negedge clock); #1;
    vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL single_rsp_clear got=%0h exp=0", rsp_valid); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL single_idle got=%0h exp=0", busy); end
    vectors++; if (dp_in !== 41'h0DE_ADBE_EF42) begin miscompares++; $display("[TB] FAIL single_dp_in_hold got=%0h exp=0deadbeef42", dp_in); end
  endtask

  task automatic test_round_robin();
    int expIdx [5] = '{0, 1, 2, 3, 0};
    int gcount = 0;
    int lastC = 0;
    int lastIdx = 0;
    bit chkPending = 1'b0;
    logic [40:0] expDin = '0;
    rst_n = 1'b0;
    @(negedge clock);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) req_data[k*41 +: 41] = rrData[k];
    req_valid = 4'b1111; rsp_ready = 1'b1; dp_out = 21'h0F00F;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (chkPending) begin
        vectors++; if (dp_in !== expDin) begin miscompares++; $display("[TB] FAIL rr_dp_in got=%0h exp=%0h", dp_in, expDin); end
        chkPending = 1'b0;
      end
      if (rsp_valid) begin
        vectors++; if (rsp_id !== 2'(lastIdx)) begin miscompares++; $display("[TB] FAIL rr_rsp_id got=%0d exp=%0d", rsp_id, lastIdx); end
      end
      if (req_ready != 4'b0 && gcount < 5) begin
        vectors++; if (req_ready !== 4'(1 << expIdx[gcount])) begin miscompares++; $display("[TB] FAIL rr_grant%0d got=%b exp=%b", gcount, req_ready, 4'(1 << expIdx[gcount])); end
        if (gcount > 0) begin
          vectors++; if (c - lastC !== 4) begin miscompares++; $display("[TB] FAIL rr_spacing%0d got=%0d exp=4", gcount, c - lastC); end
        end
        lastC = c;
        lastIdx = expIdx[gcount];
        expDin = rrData[expIdx[gcount]];
        chkPending = 1'b1;
        gcount++;
      end
      @(negedge clock);
    end
    req_valid = 4'b0000;
    vectors++; if (gcount !== 5) begin miscompares++; $display("[TB] FAIL rr_grant_count got=%0d exp=5", gcount); end
    @(negedge clock);
  endtask

  task automatic test_pointer_skip();
    logic [3:0] g;
    int n;
    req_valid = 4'b0010; rsp_ready = 1'b1;
    wait_grant(g);
    vectors++; if (g !== 4'b0010) begin miscompares++; $display("[TB] FAIL skip_setup_grant got=%b exp=0010", g); end
    wait_rsp(n);
    req_valid = 4'b1001;
    @(negedge clock);
    wait_grant(g);
    vectors++; if (g !== 4'b1000) begin miscompares++; $display("[TB] FAIL skip_grant3 got=%b exp=1000", g); end
    wait_rsp(n);
    @(negedge clock);
    wait_grant(g);
    vectors++; if (g !== 4'b0001) begin miscompares++; $display("[TB] FAIL skip_grant0 got=%b exp=0001", g); end
    @(negedge clock);
    req_valid = 4'b0000;
    wait_rsp(n);
    @(negedge clock);
  endtask

  task automatic test_backpressure();
    logic [3:0] g;
    int n;
    req_valid = 4'b0100; rsp_ready = 1'b0; dp_out = 21'h15A5A5;
    wait_grant(g);
    vectors++; if (g !== 4'b0100) begin miscompares++; $display("[TB] FAIL bp_grant got=%b exp=0100", g); end
    @(negedge clock);
    req_valid = 4'b1111;
    wait_rsp(n);
    vectors++; if (n !== 2) begin miscompares++; $display("[TB] FAIL bp_latency got=%0d exp=2", n); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      dp_out = ~dp_out;
      #1;
      vectors++; if (rsp_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL bp_rsp_valid%0d got=%0h exp=1", i, rsp_valid); end
      vectors++; if (rsp_data !== 21'h15A5A5) begin miscompares++; $display("[TB] FAIL bp_rsp_data%0d got=%0h exp=15a5a5", i, rsp_data); end
      vectors++; if (rsp_id !== 2'd2) begin miscompares++; $display("[TB] FAIL bp_rsp_id%0d got=%0d exp=2", i, rsp_id); end
      vectors++; if (req_ready !== 4'b0000) begin miscompares++; $display("[TB] FAIL bp_req_ready%0d got=%b exp=0000", i, req_ready); end
      vectors++; if (busy !== 1'b1) begin miscompares++; $display("[TB] FAIL bp_busy%0d got=%0h exp=1", i, busy); end
    end
    rsp_ready = 1'b1;
    @(negedge clock); #1;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL bp_idle_busy got=%0h exp=0", busy); end
    vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL bp_idle_rsp_valid got=%0h exp=0", rsp_valid); end
    vectors++; if (req_ready !== 4'b1000) begin miscompares++; $display("[TB] FAIL bp_idle_grant got=%b exp=1000", req_ready); end
    req_valid = 4'b0000;
    @(negedge clock); #1;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL bp_withdraw_busy got=%0h exp=0", busy); end
  endtask

  task automatic test_reset_mid();
    logic [3:0] g;
    int n;
    @(negedge clock);
    req_valid = 4'b0100; rsp_ready = 1'b1;
    wait_grant(g);
    vectors++; if (g !== 4'b0100) begin miscompares++; $display("[TB] FAIL mid_grant got=%b exp=0100", g); end
    @(negedge clock);
    req_valid = 4'b0000;
    @(posedge clock);
    #2;
    rst_n = 1'b0;
    #1;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_busy got=%0h exp=0", busy); end
    vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_rsp_valid got=%0h exp=0", rsp_valid); end
    vectors++; if (dp_in !== 41'h0) begin miscompares++; $display("[TB] FAIL mid_dp_in got=%0h exp=0", dp_in); end
    vectors++; if (rsp_id !== 2'd0) begin miscompares++; $display("[TB] FAIL mid_rsp_id got=%0d exp=0", rsp_id); end
    vectors++; if (rsp_data !== 21'h0) begin miscompares++; $display("[TB] FAIL mid_rsp_data got=%0h exp=0", rsp_data); end
    req_valid = 4'b1111;
    @(negedge clock); #1;
    vectors++; if (req_ready !== 4'b0000) begin miscompares++; $display("[TB] FAIL mid_ready_in_reset got=%b exp=0000", req_ready); end
    vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_no_response got=%0h exp=0", rsp_valid); end
    @(negedge clock);
    rst_n = 1'b1;
    wait_grant(g);
    vectors++; if (g !== 4'b0001) begin miscompares++; $display("[TB] FAIL mid_first_grant got=%b exp=0001", g); end
    @(negedge clock);
    req_valid = 4'b0000;
    wait_rsp(n);
    @(negedge clock);
  endtask

  task automatic test_settle1();
    int g1c = -1;
    int g2c = -1;
    int rspC = -1;
    logic [3:0] g1 = '0;
    logic [3:0] g2 = '0;
    for (int k = 0; k < 4; k++) bReqData[k*41 +: 41] = rrData[k];
    bReqValid = 4'b0011; bRspReady = 1'b1; bDpOut = 21'h0ABCD;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (bReqReady != 4'b0) begin
        if (g1c < 0) begin g1c = c; g1 = bReqReady; end
        else if (g2c < 0) begin g2c = c; g2 = bReqReady; end
      end
      if (bRspValid && rspC < 0) rspC = c;
      @(negedge clock);
    end
    bReqValid = 4'b0000;
    vectors++; if (g1 !== 4'b0001) begin miscompares++; $display("[TB] FAIL s1_grant_first got=%b exp=0001", g1); end
    vectors++; if (g2 !== 4'b0010) begin miscompares++; $display("[TB] FAIL s1_grant_second got=%b exp=0010", g2); end
    vectors++; if (rspC - g1c !== 2) begin miscompares++; $display("[TB] FAIL s1_latency got=%0d exp=2", rspC - g1c); end
    vectors++; if (g2c - g1c !== 3) begin miscompares++; $display("[TB] FAIL s1_spacing got=%0d exp=3", g2c - g1c); end
    @(negedge clock); #1;
    vectors++; if (bRspData !== 21'h0ABCD) begin miscompares++; $display("[TB] FAIL s1_rsp_data got=%0h exp=0abcd", bRspData); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_pointer_skip();
    test_backpressure();
    test_reset_mid();
    test_settle1();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, vectors=%0d", vectors);
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/shared_dp_scheduler.md
SHARED_DP_SCHEDULER -- requirements
Module: shared_dp_scheduler

Interface
REQ-001 SHALL have parameter NREQ, default 4: number of requesters sharing one combinational datapath instance.
REQ-002 SHALL have parameter IN_W, default 41: datapath input vector width.
REQ-003 SHALL have parameter OUT_W, default 21: datapath output vector width.
REQ-004 SHALL have parameter SETTLE, default 2: cycles allowed for datapath propagation; legal range 1..15.
REQ-005 SHALL have one clock and an asynchronous active-low reset, with these ports:
- clock  in  1  sole clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
REQ-006 SHALL have the remaining ports:
- req_valid  in  NREQ  request pending per requester.
- req_ready  out  NREQ  one-hot grant/accept.
- req_data  in  NREQ*IN_W  requester k's vector at bits [k*IN_W +: IN_W].
- dp_in  out  IN_W  registered vector driven to the datapath.
- dp_out  in  OUT_W  datapath result.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts result.
- rsp_id  out  clog2(NREQ)  index of the requester owning the result.
- rsp_data  out  OUT_W  captured result.
- busy  out  1  high whenever the state is not IDLE.

Function
REQ-007 SHALL implement the states IDLE, SETTLE and RESP, and no others.
REQ-008 In IDLE with any req_valid set, SHALL combinationally assert req_ready for exactly one index g. g is the first set req_valid bit searched round-robin from ptr+1 modulo NREQ.
REQ-009 req_ready SHALL be all-zero outside IDLE, when req_valid is all-zero, and while rst_n is low.
REQ-010 On the accept edge (IDLE and req_valid[g] high), SHALL register req_data[g] into dp_in and g into rsp_id.
REQ-011 On the accept edge, SHALL set ptr to g, load the settle counter with SETTLE and enter SETTLE.
REQ-012 In SETTLE, SHALL decrement the counter each cycle.
REQ-013 On the edge where the counter equals 1, SHALL capture dp_out into rsp_data, set rsp_valid and enter RESP.
REQ-014 Latency SHALL be fixed: rsp_valid rises SETTLE+1 cycles after the accept cycle, independent of data.
REQ-015 In RESP, rsp_valid, rsp_data and rsp_id SHALL hold stable until rsp_ready is high; changes on dp_out after capture SHALL NOT affect rsp_data.
REQ-016 On the rsp_valid&rsp_ready edge, SHALL clear rsp_valid and return to IDLE. No new request is accepted in that same cycle, so at most one transaction is in flight.
REQ-017 dp_in SHALL hold its value from the accept edge until the next accept edge, including while in IDLE.
REQ-018 Requesters SHALL hold req_valid and req_data until accepted. The block SHALL tolerate req_valid deasserting before grant, with no grant and no state change.
REQ-019 With continuous requests and rsp_ready high, each transaction SHALL occupy SETTLE+2 cycles (IDLE, SETTLE×SETTLE, RESP).
REQ-020 SHALL drive busy high in SETTLE and RESP and low in IDLE.

Reset
REQ-021 While rst_n is low, independent of clock, SHALL hold state IDLE and outputs dp_in=0, rsp_data=0, rsp_id=0, rsp_valid=0, busy=0 and req_ready=0.
REQ-022 While rst_n is low, SHALL hold the counter at 0 and ptr at NREQ-1, so that requester 0 wins first.
REQ-023 Reset asserted mid-SETTLE or mid-RESP SHALL abort the transaction, discarding the pending result without a response.
REQ-024 The first grant after rst_n rises SHALL follow the rule of REQ-008 from ptr=NREQ-1.

Verification
REQ-025 Single request scenario: after reset, req_valid=0001 with req_data[0]=V and rsp_ready=1.
- Required: req_ready=0001 in the same cycle; dp_in=V next cycle.
- Required: rsp_valid high 3 cycles after accept, with rsp_id=0 and rsp_data equal to dp_out sampled on the capture edge.
REQ-026 Round-robin scenario: req_valid=1111 held, rsp_ready=1.
- Required: grant order 0,1,2,3,0.
- Required: accepts exactly 4 cycles apart.
REQ-027 Pointer skip scenario: ptr=1, req_valid=1001.
- Required: grant 3.
- Required: next grant 0 if both are still pending.
REQ-028 Backpressure scenario: rsp_ready=0 for 10 cycles in RESP while dp_out toggles.
- Required: rsp_valid, rsp_data and rsp_id unchanged throughout; req_ready=0 and busy=1 throughout.
- Required: when rsp_ready rises, IDLE follows on the next cycle.
REQ-029 Reset mid-operation scenario: rst_n pulled low asynchronously in the second SETTLE cycle.
- Required: all outputs zero before the next clock edge; no response is issued.
- Required: after release with req_valid=1111, grant goes to 0.
REQ-030 Parameter scenario: SETTLE=1.
- Required: rsp_valid 2 cycles after accept.
- Required: back-to-back accepts 3 cycles apart.
